// File: rtl/ibex_multdiv_issue_pkg.sv
// Shared types for the mult/div issue stage: operator encoding, issue FSM states
// and the divide-by-zero quotient returned by the optional fast path.
package ibex_multdiv_issue_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        MDI_IDLE  = 2'd0,
        MDI_BUSY  = 2'd1,
        MDI_RESP  = 2'd2,
        MDI_DRAIN = 2'd3
    } md_issue_state_e;

    localparam logic [31:0] MD_DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/ibex_multdiv_issue_if.sv
// Bundle of request, response and engine-side signals of the mult/div issue stage.
// slave = the issue block itself; master = issue logic, response consumer and engine.
interface ibex_multdiv_issue_if;
    import ibex_multdiv_issue_pkg::*;

    // Both channels: a transfer happens on a rising clock edge where valid and ready are
    // both high; the sender holds valid and payload stable until that edge.
    logic            req_valid_i;
    logic            req_ready_o;
    md_op_e          req_operator_i;
    logic [1:0]      req_signed_mode_i;
    logic [31:0]     req_op_a_i;
    logic [31:0]     req_op_b_i;
    logic            req_kill_i;

    logic            mult_en_o;
    logic            div_en_o;
    md_op_e          operator_o;
    logic [1:0]      signed_mode_o;
    logic [31:0]     op_a_o;
    logic [31:0]     op_b_o;
    logic            valid_i;
    logic [31:0]     multdiv_result_i;

    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [31:0]     rsp_result_o;
    logic            err_timeout_o;
    md_issue_state_e dbg_state_o;

    modport slave (
        input  req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i,
        input  req_kill_i, valid_i, multdiv_result_i, rsp_ready_i,
        output req_ready_o, mult_en_o, div_en_o, operator_o, signed_mode_o, op_a_o, op_b_o,
        output rsp_valid_o, rsp_result_o, err_timeout_o, dbg_state_o
    );

    modport master (
        output req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i,
        output req_kill_i, valid_i, multdiv_result_i, rsp_ready_i,
        input  req_ready_o, mult_en_o, div_en_o, operator_o, signed_mode_o, op_a_o, op_b_o,
        input  rsp_valid_o, rsp_result_o, err_timeout_o, dbg_state_o
    );

endinterface

// File: rtl/ibex_multdiv_issue.sv
// Initiator side of the slow mult/div engine: latches one request, holds the engine
// controls until valid_i, then returns the result. IBEX_MD_ISSUE_DIV_ZERO_FAST_EN answers DIV/REM by zero locally.
module ibex_multdiv_issue
    import ibex_multdiv_issue_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = 40,
    parameter int unsigned CNT_W      = 6
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    ibex_multdiv_issue_if.slave md_if
);

`ifdef IBEX_MD_ISSUE_DIV_ZERO_FAST_EN
    localparam bit DIV_ZERO_FAST = 1'b1;
`else
    localparam bit DIV_ZERO_FAST = 1'b0;
`endif

    md_issue_state_e  state_q, state_d;
    md_op_e           operator_q, operator_d;
    logic [1:0]       signed_mode_q, signed_mode_d;
    logic [31:0]      op_a_q, op_a_d;
    logic [31:0]      op_b_q, op_b_d;
    logic [31:0]      result_q, result_d;
    logic             mult_en_q, mult_en_d;
    logic             div_en_q, div_en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic req_ready;
    logic accept;
    logic div_zero_fast;
    logic wd_active;
    logic wd_enter;

    always_comb begin
        state_d       = state_q;
        operator_d    = operator_q;
        signed_mode_d = signed_mode_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        result_d      = result_q;
        mult_en_d     = mult_en_q;
        div_en_d      = div_en_q;
        cnt_d         = cnt_q;
        timeout_d     = timeout_q;
        req_ready     = 1'b0;

        case (state_q)
            MDI_IDLE: begin
                req_ready = ~md_if.req_kill_i;
            end
            MDI_BUSY: begin
                // Enable drops on the valid_i edge so the engine never starts a second pass.
                if (md_if.valid_i) begin
                    mult_en_d = 1'b0;
                    div_en_d  = 1'b0;
                    if (md_if.req_kill_i) begin
                        state_d = MDI_IDLE;
                    end else begin
                        result_d = md_if.multdiv_result_i;
                        state_d  = MDI_RESP;
                    end
                end else if (md_if.req_kill_i) begin
                    state_d = MDI_DRAIN;
                end
            end
            MDI_DRAIN: begin
                // The engine freezes without its enable, so it must run to completion here.
                if (md_if.valid_i) begin
                    mult_en_d = 1'b0;
                    div_en_d  = 1'b0;
                    state_d   = MDI_IDLE;
                end
            end
            MDI_RESP: begin
                req_ready = md_if.rsp_ready_i & ~md_if.req_kill_i;
                if (md_if.req_kill_i || md_if.rsp_ready_i) begin
                    state_d = MDI_IDLE;
                end
            end
            default: begin
                state_d = MDI_IDLE;
            end
        endcase

        accept        = md_if.req_valid_i & req_ready;
        div_zero_fast = DIV_ZERO_FAST & md_if.req_operator_i[1] & (md_if.req_op_b_i == '0);

        // Accept overrides the IDLE/RESP exit above, giving back-to-back issue from RESP.
        if (accept) begin
            operator_d    = md_if.req_operator_i;
            signed_mode_d = md_if.req_signed_mode_i;
            op_a_d        = md_if.req_op_a_i;
            op_b_d        = md_if.req_op_b_i;
            if (div_zero_fast) begin
                result_d  = (md_if.req_operator_i == MD_OP_DIV) ? MD_DIV_ZERO_QUOT
                                                                 : md_if.req_op_a_i;
                mult_en_d = 1'b0;
                div_en_d  = 1'b0;
                state_d   = MDI_RESP;
            end else begin
                mult_en_d = ~md_if.req_operator_i[1];
                div_en_d  = md_if.req_operator_i[1];
                state_d   = MDI_BUSY;
            end
        end

        wd_active = (state_q == MDI_BUSY) || (state_q == MDI_DRAIN);
        wd_enter  = ((state_d == MDI_BUSY) || (state_d == MDI_DRAIN)) && (state_d != state_q);
        if (wd_enter) begin
            cnt_d = '0;
        end else if (wd_active && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (wd_active && (cnt_q >= CNT_W'(MAX_CYCLES - 1))) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= MDI_IDLE;
            operator_q    <= MD_OP_MULL;
            signed_mode_q <= 2'b00;
            op_a_q        <= '0;
            op_b_q        <= '0;
            result_q      <= '0;
            mult_en_q     <= 1'b0;
            div_en_q      <= 1'b0;
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            operator_q    <= operator_d;
            signed_mode_q <= signed_mode_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            result_q      <= result_d;
            mult_en_q     <= mult_en_d;
            div_en_q      <= div_en_d;
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
        end
    end

    assign md_if.req_ready_o   = req_ready;
    assign md_if.mult_en_o     = mult_en_q;
    assign md_if.div_en_o      = div_en_q;
    assign md_if.operator_o    = operator_q;
    assign md_if.signed_mode_o = signed_mode_q;
    assign md_if.op_a_o        = op_a_q;
    assign md_if.op_b_o        = op_b_q;
    assign md_if.rsp_valid_o   = (state_q == MDI_RESP);
    assign md_if.rsp_result_o  = result_q;
    assign md_if.err_timeout_o = timeout_q;
    assign md_if.dbg_state_o   = state_q;

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Bench for ibex_multdiv_issue: behavioural slow engine, directed scenarios, then
// randomized traffic against a queue-based model of expected responses.
module tb_ibex_multdiv_issue;
    import ibex_multdiv_issue_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ibex_multdiv_issue_if md_if();

    ibex_multdiv_issue #(.MAX_CYCLES(40), .CNT_W(6)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .md_if (md_if.slave)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    int          cyc = 0;
    int          last_valid_cyc = -100;
    int          acc_cnt = 0;
    int          eng_lat = 4;
    int          eng_cnt = 0;
    bit          eng_stall = 1'b0;
    bit          inject_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // RISC-V M-extension arithmetic; DIV/REM are signed when operand A is flagged signed.
    function automatic logic [31:0] md_ref(input logic [1:0] op, input logic [1:0] mode,
                                           input logic [31:0] a, input logic [31:0] b);
        logic signed [32:0] sa;
        logic signed [32:0] sb;
        logic signed [65:0] prod;
        logic               sgn;
        sa   = mode[0] ? $signed({a[31], a}) : $signed({1'b0, a});
        sb   = mode[1] ? $signed({b[31], b}) : $signed({1'b0, b});
        prod = sa * sb;
        sgn  = mode[0];
        case (op)
            2'd0: return prod[31:0];
            2'd1: return prod[63:32];
            2'd2: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                if (sgn) return $signed(a) / $signed(b);
                return a / b;
            end
            default: begin
                if (b == 32'd0) return a;
                if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                if (sgn) return $signed(a) % $signed(b);
                return a % b;
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural engine: counts enabled cycles, pulses valid_i once, freezes when disabled.
    initial begin
        md_if.valid_i          = 1'b0;
        md_if.multdiv_result_i = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                md_if.valid_i = 1'b0;
                eng_cnt       = 0;
            end else if (md_if.valid_i) begin
                md_if.valid_i          = 1'b0;
                md_if.multdiv_result_i = $urandom;
                eng_cnt                = 0;
            end else if (inject_valid) begin
                md_if.valid_i          = 1'b1;
                md_if.multdiv_result_i = $urandom;
            end else if ((md_if.mult_en_o || md_if.div_en_o) && !eng_stall) begin
                eng_cnt++;
                if (eng_cnt >= eng_lat) begin
                    md_if.valid_i          = 1'b1;
                    md_if.multdiv_result_i = md_ref(md_if.operator_o, md_if.signed_mode_o,
                                                    md_if.op_a_o, md_if.op_b_o);
                end
            end else if (!(md_if.mult_en_o || md_if.div_en_o)) begin
                eng_cnt = 0;
            end
        end
    end

    // Scoreboard: requests push their expected result, kills discard it, responses pop it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (md_if.valid_i && (md_if.mult_en_o || md_if.div_en_o)) last_valid_cyc = cyc;
                if (md_if.rsp_valid_o && md_if.rsp_ready_i) begin
                    if (exp_q.size() > 0) check("rsp_data", md_if.rsp_result_o, exp_q.pop_front());
                    else check("rsp_extra", md_if.rsp_valid_o, 1'b0);
                end else if (exp_q.size() == 0) begin
                    check("rsp_idle", md_if.rsp_valid_o, 1'b0);
                end
                if (md_if.req_kill_i) exp_q.delete();
                if (md_if.req_valid_i && md_if.req_ready_o) begin
                    exp_q.push_back(md_ref(md_if.req_operator_i, md_if.req_signed_mode_i,
                                           md_if.req_op_a_i, md_if.req_op_b_i));
                    acc_cnt++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "simulation time limit");
    end

    task automatic drive_req(input logic [1:0] op, input logic [1:0] mode,
                             input logic [31:0] a, input logic [31:0] b);
        md_if.req_valid_i       = 1'b1;
        md_if.req_operator_i    = md_op_e'(op);
        md_if.req_signed_mode_i = mode;
        md_if.req_op_a_i        = a;
        md_if.req_op_b_i        = b;
    endtask

    task automatic rand_req();
        logic [1:0]  op;
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        op   = 2'($urandom_range(0, 3));
        mode = op[1] ? ($urandom_range(0, 1) != 0 ? 2'b11 : 2'b00) : 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
            0: a = 32'h8000_0000;
            1: a = 32'($urandom_range(0, 100));
            default: a = $urandom;
        endcase
        case ($urandom_range(0, 4))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 20));
            default: b = $urandom;
        endcase
        eng_lat = $urandom_range(1, 30);
        drive_req(op, mode, a, b);
    endtask

    // Returns at the negedge where rsp_valid_o is first seen (or after the budget).
    task automatic wait_rsp(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (md_if.rsp_valid_o) break;
        end
        check(tag, md_if.rsp_valid_o, 1'b1);
    endtask

    initial begin
        int prev_acc;
        md_if.req_valid_i       = 1'b0;
        md_if.req_operator_i    = MD_OP_MULL;
        md_if.req_signed_mode_i = 2'b00;
        md_if.req_op_a_i        = 32'd0;
        md_if.req_op_b_i        = 32'd0;
        md_if.req_kill_i        = 1'b0;
        md_if.rsp_ready_i       = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", md_if.req_ready_o, 1'b1);
        check("rst_mult_en", md_if.mult_en_o, 1'b0);
        check("rst_div_en", md_if.div_en_o, 1'b0);
        check("rst_rsp_valid", md_if.rsp_valid_o, 1'b0);
        check("rst_timeout", md_if.err_timeout_o, 1'b0);
        check("rst_op_a", md_if.op_a_o, 32'd0);
        check("rst_result", md_if.rsp_result_o, 32'd0);
        rst_n = 1'b1;

        // MULL 7*6, then a signed DIV queued behind it for back-to-back issue
        @(posedge clk); #1;
        eng_lat = 4;
        drive_req(2'd0, 2'b00, 32'd7, 32'd6);
        @(negedge clk);
        check("t1_req_ready", md_if.req_ready_o, 1'b1);
        @(posedge clk); #1;
        drive_req(2'd2, 2'b11, 32'hFFFF_FFEC, 32'd3);
        @(negedge clk);
        check("t1_mult_en", md_if.mult_en_o, 1'b1);
        check("t1_div_en", md_if.div_en_o, 1'b0);
        check("t1_op_a", md_if.op_a_o, 32'd7);
        check("t1_op_b", md_if.op_b_o, 32'd6);
        check("t1_operator", md_if.operator_o, 32'd0);
        check("t1_busy_ready", md_if.req_ready_o, 1'b0);
        wait_rsp("t1_rsp_wait");
        check("t1_latency", cyc - last_valid_cyc, 32'd1);
        check("t1_result", md_if.rsp_result_o, 32'd42);
        check("t1_mult_en_drop", md_if.mult_en_o, 1'b0);
        check("t2_b2b_ready", md_if.req_ready_o, 1'b1);
        @(posedge clk); #1;
        md_if.req_valid_i = 1'b0;
        @(negedge clk);
        check("t2_no_gap_div_en", md_if.div_en_o, 1'b1);
        check("t1_one_pulse", md_if.rsp_valid_o, 1'b0);
        check("t2_operator", md_if.operator_o, 32'd2);
        check("t2_op_a", md_if.op_a_o, 32'hFFFF_FFEC);
        wait_rsp("t2_rsp_wait");
        check("t2_result", md_if.rsp_result_o, 32'hFFFF_FFFA);
        @(posedge clk); #1;

        // Kill in BUSY cycle 10 of a long divide
        eng_lat = 20;
        drive_req(2'd2, 2'b00, 32'd1000, 32'd7);
        @(negedge clk);
        check("t3_req_ready", md_if.req_ready_o, 1'b1);
        @(posedge clk); #1;
        md_if.req_valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        md_if.req_kill_i = 1'b1;
        @(posedge clk); #1;
        md_if.req_kill_i = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("t3_drain_div_en", md_if.div_en_o, 1'b1);
            check("t3_drain_no_rsp", md_if.rsp_valid_o, 1'b0);
            if (md_if.valid_i) break;
        end
        @(negedge clk);
        check("t3_div_en_drop", md_if.div_en_o, 1'b0);
        check("t3_no_rsp", md_if.rsp_valid_o, 1'b0);
        check("t3_ready_after", md_if.req_ready_o, 1'b1);
        @(posedge clk); #1;

        // REM 9 by 0
        eng_lat = 6;
        drive_req(2'd3, 2'b00, 32'd9, 32'd0);
        @(negedge clk);
        check("t4_req_ready", md_if.req_ready_o, 1'b1);
        @(posedge clk); #1;
        md_if.req_valid_i = 1'b0;
`ifdef IBEX_MD_ISSUE_DIV_ZERO_FAST_EN
        @(negedge clk);
        check("t4_fast_rsp", md_if.rsp_valid_o, 1'b1);
        check("t4_fast_result", md_if.rsp_result_o, 32'd9);
        check("t4_fast_no_div_en", md_if.div_en_o, 1'b0);
`else
        @(negedge clk);
        check("t4_div_en", md_if.div_en_o, 1'b1);
        wait_rsp("t4_rsp_wait");
        check("t4_result", md_if.rsp_result_o, 32'd9);
`endif
        @(posedge clk); #1;

        // Response back-pressure with stray valid_i pulses and a pending request
        eng_lat = 3;
        md_if.rsp_ready_i = 1'b0;
        drive_req(2'd1, 2'b01, 32'hFFFF_FFFD, 32'd5);
        @(negedge clk);
        check("t6_req_ready", md_if.req_ready_o, 1'b1);
        @(posedge clk); #1;
        drive_req(2'd0, 2'b00, 32'd3, 32'd3);
        wait_rsp("t6_rsp_wait");
        for (int i = 0; i < 5; i++) begin
            check("t6_hold_result", md_if.rsp_result_o, 32'hFFFF_FFFF);
            check("t6_hold_valid", md_if.rsp_valid_o, 1'b1);
            check("t6_hold_ready", md_if.req_ready_o, 1'b0);
            inject_valid = (i == 1 || i == 3);
            @(negedge clk);
        end
        inject_valid = 1'b0;
        check("t6_after_result", md_if.rsp_result_o, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        md_if.rsp_ready_i = 1'b1;
        @(negedge clk);
        check("t6_release_ready", md_if.req_ready_o, 1'b1);
        @(posedge clk); #1;
        md_if.req_valid_i = 1'b0;
        wait_rsp("t6_next_wait");
        check("t6_next_result", md_if.rsp_result_o, 32'd9);
        @(posedge clk); #1;

        // Engine that never answers: watchdog, then asynchronous reset mid-op
        eng_stall = 1'b1;
        drive_req(2'd0, 2'b00, 32'd5, 32'd5);
        @(negedge clk);
        check("t5_req_ready", md_if.req_ready_o, 1'b1);
        @(posedge clk); #1;
        md_if.req_valid_i = 1'b0;
        repeat (39) @(posedge clk);
        @(negedge clk);
        check("t5_timeout_39", md_if.err_timeout_o, 1'b0);
        @(negedge clk);
        check("t5_timeout_40", md_if.err_timeout_o, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_timeout_sticky", md_if.err_timeout_o, 1'b1);
            check("t5_still_busy", md_if.mult_en_o, 1'b1);
        end
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_arst_ready", md_if.req_ready_o, 1'b1);
        check("t5_arst_mult_en", md_if.mult_en_o, 1'b0);
        check("t5_arst_timeout", md_if.err_timeout_o, 1'b0);
        check("t5_arst_rsp_valid", md_if.rsp_valid_o, 1'b0);
        check("t5_arst_op_a", md_if.op_a_o, 32'd0);
        check("t5_arst_op_b", md_if.op_b_o, 32'd0);
        check("t5_arst_operator", md_if.operator_o, 32'd0);
        check("t5_arst_result", md_if.rsp_result_o, 32'd0);
        eng_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic: held requests, back-pressure and occasional kills
        prev_acc = acc_cnt;
        for (int c = 0; c < 6000 && acc_cnt < prev_acc + 150; c++) begin
            @(posedge clk); #1;
            if (!md_if.req_valid_i || acc_cnt != prev_acc) begin
                prev_acc = (acc_cnt != prev_acc) ? acc_cnt : prev_acc;
                if ($urandom_range(0, 2) != 0) rand_req();
                else md_if.req_valid_i = 1'b0;
            end
            md_if.rsp_ready_i = ($urandom_range(0, 3) != 0);
            md_if.req_kill_i  = ($urandom_range(0, 30) == 0) &&
                                !(md_if.rsp_valid_o && md_if.rsp_ready_i);
        end
        @(posedge clk); #1;
        md_if.req_valid_i = 1'b0;
        md_if.req_kill_i  = 1'b0;
        md_if.rsp_ready_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !md_if.rsp_valid_o) break;
        end
        check("rand_drain_empty", exp_q.size(), 32'd0);
        check("rand_no_timeout", md_if.err_timeout_o, 1'b0);
        check("rand_idle_ready", md_if.req_ready_o, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
